// File: rtl/axis_pkt_arbiter.sv
// Packet-locked round-robin arbiter for two AXI-Stream sources sharing one sink.
// Optional per-port completed-packet counters are built when AXIS_ARB_PKT_CNT_EN is defined.
module axis_pkt_arbiter #(
  parameter int DATA_WIDTH = 8
`ifdef AXIS_ARB_PKT_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] DATA_in_0,
  input  logic                  TVALID_in_0,
  input  logic                  TLAST_in_0,
  output logic                  TREADY_in_0,
  input  logic [DATA_WIDTH-1:0] DATA_in_1,
  input  logic                  TVALID_in_1,
  input  logic                  TLAST_in_1,
  output logic                  TREADY_in_1,
  output logic [DATA_WIDTH-1:0] DATA_out,
  output logic                  TVALID_out,
  output logic                  TLAST_out,
  input  logic                  TREADY_out,
  output logic                  sel,
  output logic                  busy
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_1
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   sel_q;
  logic   pkt_end;

  // Handshake: a beat moves on TVALID_out & TREADY_out; TVALID_out never depends on
  // TREADY_out, and only the granted source ever sees TREADY_out.
  assign pkt_end = TVALID_out & TREADY_out & TLAST_out;
  assign sel     = sel_q;
  assign busy    = (state_q != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      if (state_d == GNT0) begin
        sel_q <= 1'b0;
      end else if (state_d == GNT1) begin
        sel_q <= 1'b1;
      end
    end
  end

  // On a packet end only the other port may take over; the finishing source's own
  // TVALID still belongs to the beat being consumed.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (TVALID_in_0 && (!TVALID_in_1 || last_gnt_q)) begin
          state_d = GNT0;
        end else if (TVALID_in_1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (pkt_end) begin
          last_gnt_d = 1'b0;
          state_d    = TVALID_in_1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (pkt_end) begin
          last_gnt_d = 1'b1;
          state_d    = TVALID_in_0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TVALID_out  = 1'b0;
    TLAST_out   = 1'b0;
    TREADY_in_0 = 1'b0;
    TREADY_in_1 = 1'b0;
    DATA_out    = sel_q ? DATA_in_1 : DATA_in_0;
    case (state_q)
      GNT0: begin
        TVALID_out  = TVALID_in_0;
        TLAST_out   = TLAST_in_0;
        TREADY_in_0 = TREADY_out;
      end
      GNT1: begin
        TVALID_out  = TVALID_in_1;
        TLAST_out   = TLAST_in_1;
        TREADY_in_1 = TREADY_out;
      end
      default: ;
    endcase
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
    end else begin
      if (pkt_end && (state_q == GNT0)) pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
      if (pkt_end && (state_q == GNT1)) pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
    end
  end
`endif

endmodule
